// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM state type and op-class helper for the multiply/divide unit
// Purpose: shared definitions for mdu_arith and mdu_ctrl.
//   MD_* : 3-bit operation codes carried on the op port
//   mdu_state_e : sequencer states (IDLE, RUN)
//   is_md_arith : true for the ops that take the multi-cycle path
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide result generator
// Purpose: produces the HI/LO values a MULT/MULTU/DIV/DIVU would leave behind.
// Ports:
//   op            in  3   operation code
//   rs_val/rt_val in  32  operands (rs is dividend / multiplicand)
//   cur_hi/cur_lo in  32  current HI/LO, returned unchanged for divide-by-zero and non-arith ops
//   res_hi/res_lo out 32  resulting HI/LO
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0]        w_rs_sext;
  logic [63:0]        w_rt_sext;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;
  logic               w_div_zero;
  logic               w_div_ovf;

  assign w_rs_sext = {{32{rs_val[31]}}, rs_val};
  assign w_rt_sext = {{32{rt_val[31]}}, rt_val};
  assign w_prod_s  = w_rs_sext * w_rt_sext;
  assign w_prod_u  = {32'd0, rs_val} * {32'd0, rt_val};

  assign w_div_zero = (rt_val == 32'd0);
  // Most-negative / -1 is the only signed quotient that does not fit; pin it explicitly.
  assign w_div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

  // Signed / and % truncate toward zero, giving a remainder with the dividend's sign.
  assign w_quot_s = w_div_zero ? 32'sd0 : $signed(rs_val) / $signed(rt_val);
  assign w_rem_s  = w_div_zero ? 32'sd0 : $signed(rs_val) % $signed(rt_val);
  assign w_quot_u = w_div_zero ? 32'd0 : rs_val / rt_val;
  assign w_rem_u  = w_div_zero ? 32'd0 : rs_val % rt_val;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MD_MULT: begin
        res_hi = w_prod_s[63:32];
        res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = w_prod_u[63:32];
        res_lo = w_prod_u[31:0];
      end
      MD_DIV: begin
        if (w_div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else if (!w_div_zero) begin
          res_hi = w_rem_s;
          res_lo = w_quot_s;
        end
      end
      MD_DIVU: begin
        if (!w_div_zero) begin
          res_hi = w_rem_u;
          res_lo = w_quot_u;
        end
      end
      default: begin
        res_hi = cur_hi;
        res_lo = cur_lo;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO
// Purpose: accepts one md op per start, counts out its latency, commits HI/LO, drives the D-stage stall.
// Ports:
//   clk, reset    in   clock, asynchronous active-high reset
//   start, op     in   md op request in E and its 3-bit code
//   rs_val/rt_val in   forwarded operands
//   flush         in   E-stage cancel; suppresses start
//   md_use_d      in   D-stage instruction touches HI/LO
//   busy, stall   out  operation in progress / hold D
//   hi, lo        out  registered HI/LO
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e    r_state;
  mdu_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;
  logic          w_req;
  logic          w_accept;
  logic          w_is_arith;
  logic          w_last;

  mdu_arith u_arith (
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cur_hi (r_hi),
    .cur_lo (r_lo),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo)
  );

  assign w_req      = start & ~flush;
  assign w_accept   = w_req & (r_state == ST_IDLE);
  assign w_is_arith = is_md_arith(op);
  assign w_last     = (r_cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_arith) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state == ST_RUN);
    // Includes the start cycle so a dependent D-stage op is held before busy rises.
    stall = md_use_d & (busy | (w_req & w_is_arith));
  end

  // Result is captured at start so operands need not be held during RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (w_accept) begin
      if (op == MD_MTHI) begin
        r_hi <= rs_val;
      end else if (op == MD_MTLO) begin
        r_lo <= rs_val;
      end else if (w_is_arith) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_cnt     <= ((op == MD_MULT) || (op == MD_MULTU)) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl against a schedule-based reference model
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        flush = 1'b0;
  logic        md_use_d = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference: HI/LO after an op, by plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] ch, input logic [31:0] cl);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = {ch, cl};
    case (o)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      3'd2: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      3'd3: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: res = {ch, cl};
    endcase
    return res;
  endfunction

  // Model state: an in-flight op commits at edge number m_commit.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic        m_pend;
  longint      m_edge, m_commit;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= 0; m_lo <= 0; m_pend <= 0; m_res <= 0; m_edge <= 0; m_commit <= 0;
    end else begin
      m_edge <= m_edge + 1;
      if (m_pend) begin
        if (m_edge == m_commit) begin
          m_hi <= m_res[63:32];
          m_lo <= m_res[31:0];
          m_pend <= 0;
        end
      end else if (start && !flush) begin
        if (op == 3'd4) m_hi <= rs_val;
        else if (op == 3'd5) m_lo <= rs_val;
        else if (op < 3'd4) begin
          m_pend   <= 1;
          m_res    <= ref_result(op, rs_val, rt_val, m_hi, m_lo);
          m_commit <= m_edge + ((op < 3'd2) ? NM : ND);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle after inputs settle.
  always @(negedge clk) begin
    logic exp_stall;
    #2;
    if (chk_en) begin
      exp_stall = md_use_d & (m_pend | (start & ~flush & (op < 3'd4)));
      check("busy", {31'd0, busy}, {31'd0, m_pend});
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    tick();
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
    #3;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] p;

    p = ref_result(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("pin_mult", p[63:32], 32'hFFFF_FFFF);
    check("pin_mult_lo", p[31:0], 32'hFFFF_FFFA);
    p = ref_result(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("pin_div_lo", p[31:0], 32'hFFFF_FFFD);
    check("pin_div_hi", p[63:32], 32'hFFFF_FFFF);
    p = ref_result(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5, 6);
    check("pin_ovf", p[31:0], 32'h8000_0000);
    check("pin_ovf_hi", p[63:32], 32'd0);
    p = ref_result(MD_DIVU, 32'd0, 32'd0, 32'h11, 32'h22);
    check("pin_div0", p[31:0], 32'h22);

    #1 reset = 1'b1;
    repeat (2) tick();
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    #3 check("mult_busy_c1", {31'd0, busy}, 32'd1);
    wait_cyc(4);
    check("mult_busy_c5", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    check("mult_busy_c6", {31'd0, busy}, 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(MD_DIVU, 32'd100, 32'd7);
    wait_cyc(9);
    check("divu_busy_c10", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_cyc(10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    issue(MD_DIV, 32'd55, 32'd0);
    wait_cyc(9);
    check("div0_busy_c10", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    tick();
    start = 1'b1; flush = 1'b1; op = MD_MULT; rs_val = 32'd9; rt_val = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0;
    #3;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);

    issue(MD_DIV, 32'd100, 32'd7);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_cyc(6);
    check("rundiv_busy_c10", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    check("rundiv_lo", lo, 32'd14);
    check("rundiv_hi", hi, 32'd2);

    tick();
    md_use_d = 1'b1; start = 1'b1; op = MD_MULT; rs_val = 32'd5; rt_val = 32'd6;
    #3 check("stall_c0", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    #3 check("stall_c1", {31'd0, stall}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      wait_cyc(1);
      check("stall_run", {31'd0, stall}, 32'd1);
    end
    wait_cyc(1);
    check("stall_c6", {31'd0, stall}, 32'd0);

    tick();
    start = 1'b1; op = MD_MTLO; rs_val = 32'hABCD;
    #3 check("mtlo_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0; md_use_d = 1'b0;
    #3;
    check("mtlo_lo", lo, 32'hABCD);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(MD_MULT, 32'd7, 32'd9);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #3;
    check("rstrun_busy", {31'd0, busy}, 32'd0);
    check("rstrun_hi", hi, 32'd0);
    check("rstrun_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    issue(MD_MULTU, 32'd2, 32'd3);
    wait_cyc(5);
    check("multu_lo", lo, 32'd6);
    check("multu_hi", hi, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      tick();
      reset    = ($urandom % 250) == 0;
      start    = ($urandom % 3) == 0;
      op       = 3'($urandom % 8);
      rs_val   = pick();
      rt_val   = pick();
      flush    = ($urandom % 8) == 0;
      md_use_d = $urandom % 2;
    end
    tick();
    reset = 1'b0; start = 1'b0; flush = 1'b0; md_use_d = 1'b0;
    repeat (12) tick();
    #3;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the E stage of the five-stage pipeline. It owns the HI/LO register pair, accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per start pulse, and counts out the fixed operation latency. It produces the busy/stall signal that the hazard unit uses to hold D while a HI/LO-dependent instruction is waiting. Starts are gated by the exception flush so that an instruction cancelled by an interrupt or exception never modifies HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  E-stage instruction is an md op this cycle
- op  in  3  operation code (mdu_pkg encodings)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- flush  in  1  exception/interrupt flush of E this cycle; suppresses start
- md_use_d  in  1  D-stage instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  operation in progress
- stall  out  1  md_use_d & (busy | (start & ~flush & op is mult/div))
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. Reset → IDLE, busy=0, counter=0, hi=0, lo=0, pending regs=0.
- IDLE, start & ~flush:
  - MTHI/MTLO: write rs_val to hi/lo at this edge; stay IDLE.
  - MULT/MULTU/DIV/DIVU: compute the result combinationally from rs_val/rt_val, latch it into pending_hi/pending_lo, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
- RUN: decrement the counter each cycle. When counter==1, copy pending into hi/lo at that edge and go to IDLE.
- start while in RUN is ignored; the hazard stall guarantees it cannot occur legally.
- flush in the same cycle as start: the op is ignored entirely and no state changes. flush during RUN does not abort; the operation belongs to an instruction that has already committed.
- Unknown op codes: ignored.
- Arithmetic:
  - MULT: {hi,lo} = signed 32×32 → 64.
  - MULTU: {hi,lo} = unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - 0x80000000 DIV 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Divisor zero: the full latency is still spent and hi/lo keep their previous values (pending is loaded with the current hi/lo).

## Timing
- start sampled at edge k → busy=1 during cycles k+1..k+N (N = MULT_CYCLES or DIV_CYCLES) → new hi/lo visible and busy=0 from cycle k+N+1.
- MTHI/MTLO: new value visible in cycle k+1; busy never asserts.
- Back-to-back: a new start is accepted in the first cycle with busy=0. A second op can begin in cycle k+N+1.
- stall is combinational. It covers the start cycle itself, so a D-stage mfhi directly behind a mult stalls immediately.
- hi/lo are registered outputs. No combinational path from rs_val/rt_val to hi/lo.
- reset asserted mid-RUN: returns to IDLE immediately and asynchronously, hi=lo=0, pending result discarded.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Structure
- mdu_pkg holds the op encodings (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5) and the state enum.
- Sub-module mdu_arith: purely combinational. It takes op, rs_val, rt_val, cur_hi and cur_lo, and returns res_hi/res_lo including the divide-by-zero and overflow rules. mdu_ctrl holds only the FSM, counter and registers.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3, start at edge 0 → busy cycles 1–5; hi=0xFFFFFFFF, lo=0xFFFFFFFA in cycle 6.
- DIVU rs=100, rt=7 → busy 10 cycles; then lo=14, hi=2. DIV rs=−7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV by 0 with hi=0x11, lo=0x22 beforehand → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MULT start with flush=1 → busy stays 0 and hi/lo unchanged. Separately, flush pulsed in cycle 3 of a running DIV → result still commits in cycle 11.
- md_use_d=1 with start=MULT → stall=1 in cycles 0–5 and 0 in cycle 6. MTLO rs=0xABCD → lo=0xABCD next cycle, busy and stall never asserted.
- reset pulsed in cycle 4 of a MULT → busy=0 and hi=lo=0 immediately; a following MULTU 2×3 gives lo=6, hi=0.
